// File: rtl/vending_machine_multi_if.sv
// Bundled I/O of the multi-item vending machine: level inputs from the customer
// panel and one-cycle pulse outputs back to the mechanism.
interface vending_machine_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 6
);
  // No back-pressure: inputs are levels sampled on every rising edge, and the
  // dispense/nickel_out/coin_reject outputs are single-cycle pulses that must be taken when seen.
  logic [NUM_ITEMS-1:0] item_number;
  logic                 nickel_in;
  logic                 dime_in;
  logic                 quarter_in;
  logic                 cancel;
  logic                 dispense;
  logic [NUM_ITEMS-1:0] dispensed_item;
  logic                 nickel_out;
  logic                 coin_reject;
  logic [CREDIT_W-1:0]  credit;
  logic                 busy;
  logic [NUM_ITEMS-1:0] sold_out;
  logic [1:0]           state_dbg;

  modport master (
    output item_number, nickel_in, dime_in, quarter_in, cancel,
    input  dispense, dispensed_item, nickel_out, coin_reject, credit, busy, sold_out, state_dbg
  );

  modport slave (
    input  item_number, nickel_in, dime_in, quarter_in, cancel,
    output dispense, dispensed_item, nickel_out, coin_reject, credit, busy, sold_out, state_dbg
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-item vending machine: coin credit, one-hot item select, nickel change.
// Optional per-item stock tracking is enabled by defining VM_STOCK_TRACK_EN.
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 6,
  parameter int PRICE_BASE = 3,
  parameter int PRICE_STEP = 1,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  vending_machine_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int             CW         = CREDIT_W + 4;
  localparam logic [CW-1:0]  CREDIT_MAX = CW'((1 << CREDIT_W) - 1);

  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d, credit_coin;
  logic [2:0]           coin_prev_q, coin_prev_d, coin_edge;
  logic                 dispense_q, dispense_d;
  logic [NUM_ITEMS-1:0] dispensed_item_q, dispensed_item_d;
  logic                 nickel_out_q, nickel_out_d;
  logic                 coin_reject_q, coin_reject_d;
  logic [3:0]           coin_sum;
  logic [CW-1:0]        credit_sum, price_sel, vend_rem;
  logic                 coin_any, coin_ovf, coin_add;
  logic                 sel_onehot, sel_valid;
  logic [NUM_ITEMS-1:0] sold_out_vec;

  // A stock reset value of zero or one that does not fit STOCK_W is a configuration error.
  if (STOCK_INIT < 1 || STOCK_INIT >= (1 << STOCK_W)) begin : g_stock_init_out_of_range
  end

  always_comb begin
    coin_prev_d = {bus.quarter_in, bus.dime_in, bus.nickel_in};
    coin_edge   = coin_prev_d & ~coin_prev_q;
    coin_sum    = {3'b000, coin_edge[0]} + {2'b00, coin_edge[1], 1'b0} +
                  (coin_edge[2] ? 4'd5 : 4'd0);
    coin_any    = |coin_edge;
    credit_sum  = CW'(credit_q) + CW'(coin_sum);
    coin_ovf    = credit_sum > CREDIT_MAX;
    coin_add    = coin_any && !coin_ovf;
    credit_coin = coin_add ? credit_sum[CREDIT_W-1:0] : credit_q;

    price_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.item_number[i]) price_sel = CW'(PRICE_BASE + i * PRICE_STEP);
    end
    sel_onehot = (bus.item_number != '0) &&
                 ((bus.item_number & (bus.item_number - NUM_ITEMS'(1))) == '0);
    // Affordability uses the pre-coin credit; a coin in the same cycle still lands.
    sel_valid  = sel_onehot && (CW'(credit_q) >= price_sel) &&
                 ((bus.item_number & sold_out_vec) == '0);
    vend_rem   = CW'(credit_coin) - price_sel;
  end

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    dispense_d       = 1'b0;
    dispensed_item_d = '0;
    nickel_out_d     = 1'b0;
    coin_reject_d    = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        coin_reject_d = coin_any && coin_ovf;
        if (bus.cancel && state_q == COLLECT && credit_q != '0) begin
          state_d      = CHANGE;
          credit_d     = credit_coin;
          nickel_out_d = 1'b1;
        end else if (sel_valid) begin
          state_d          = VEND;
          credit_d         = vend_rem[CREDIT_W-1:0];
          dispense_d       = 1'b1;
          dispensed_item_d = bus.item_number;
        end else begin
          credit_d = credit_coin;
          if (coin_add) state_d = COLLECT;
        end
      end
      VEND: begin
        coin_reject_d = coin_any;
        if (credit_q != '0) begin
          state_d      = CHANGE;
          nickel_out_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_any;
        // nickel_out is high for every CHANGE cycle; the last one is when credit is 1.
        if (credit_q <= CREDIT_W'(1)) begin
          state_d  = IDLE;
          credit_d = '0;
        end else begin
          credit_d     = credit_q - CREDIT_W'(1);
          nickel_out_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= IDLE;
      credit_q         <= '0;
      coin_prev_q      <= '0;
      dispense_q       <= 1'b0;
      dispensed_item_q <= '0;
      nickel_out_q     <= 1'b0;
      coin_reject_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      coin_prev_q      <= coin_prev_d;
      dispense_q       <= dispense_d;
      dispensed_item_q <= dispensed_item_d;
      nickel_out_q     <= nickel_out_d;
      coin_reject_q    <= coin_reject_d;
    end
  end

`ifdef VM_STOCK_TRACK_EN
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  always_comb begin
    sold_out_vec = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i]      = stock_q[i];
      if (dispense_d && dispensed_item_d[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
      sold_out_vec[i] = (stock_q[i] == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      stock_q <= stock_d;
    end
  end
`else
  assign sold_out_vec = '0;
`endif

  assign bus.dispense       = dispense_q;
  assign bus.dispensed_item = dispensed_item_q;
  assign bus.nickel_out     = nickel_out_q;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.credit         = credit_q;
  assign bus.busy           = (state_q == VEND) || (state_q == CHANGE);
  assign bus.sold_out       = sold_out_vec;
  assign bus.state_dbg      = state_q;

endmodule
